// File: rtl/round_robin_mux_arbiter.sv
// Round-robin arbiter over four requesters (F,E,C,B) muxing the owner's word onto D.
// Grant 1 cycle after request; READY low freezes D/VALID; grant released after MAX_BURST or owner drop.
module round_robin_mux_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    input  logic [3:0] f_i,
    input  logic [3:0] e_i,
    input  logic [3:0] c_i,
    input  logic [3:0] b_i,
    input  logic       ready_i,
    output logic [3:0] gnt_o,
    output logic       s1_o,
    output logic       s2_o,
    output logic [3:0] d_o,
    output logic       valid_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [4:0] MAX_BURST_W = 5'(MAX_BURST);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] dat_q, dat_d;
    logic       valid_q, valid_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [3:0] data_arr [4];
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    assign data_arr[0] = f_i;
    assign data_arr[1] = e_i;
    assign data_arr[2] = c_i;
    assign data_arr[3] = b_i;

    // Search starts just above the previous owner; k=4 wraps back onto last_q itself.
    always_comb begin
        win   = last_q + 2'd1;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    dat_d   = data_arr[win];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (valid_q && ready_i) begin
                    if (req_i[sel_q] && (({1'b0, cnt_q} + 5'd1) < MAX_BURST_W)) begin
                        cnt_d = cnt_q + 4'd1;
                        dat_d = data_arr[sel_q];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        last_d  = sel_q;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign s1_o    = sel_q[1];
    assign s2_o    = sel_q[0];
    assign d_o     = dat_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Bench for round_robin_mux_arbiter: directed literal scenarios plus a random run against a queue-free
// behavioural model (integer owner/rotation arithmetic), with burst-length and fairness monitors.
module tb_round_robin_mux_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] f = '0, e = '0, c = '0, b = '0;
    logic       ready = 1'b0;
    logic [3:0] gnt_o;
    logic       s1_o, s2_o;
    logic [3:0] d_o;
    logic       valid_o;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    round_robin_mux_arbiter #(.MAX_BURST(MB)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .f_i     (f),
        .e_i     (e),
        .c_i     (c),
        .b_i     (b),
        .ready_i (ready),
        .gnt_o   (gnt_o),
        .s1_o    (s1_o),
        .s2_o    (s2_o),
        .d_o     (d_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] word_of(input int i);
        case (i)
            0:       return f;
            1:       return e;
            2:       return c;
            default: return b;
        endcase
    endfunction

    function automatic int winner_of(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // Behavioural model: who owns the bus, how many words it has handed over, who spoke last.
    bit         m_busy;
    int         m_owner, m_sel, m_last, m_xfers;
    logic [3:0] m_d;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_sel = 0; m_d = '0; m_xfers = 0; m_last = 3;
        end else if (!m_busy) begin
            int w;
            w = winner_of(m_last, req);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_sel = w; m_d = word_of(w); m_xfers = 0;
            end
        end else if (ready) begin
            m_xfers++;
            if (req[m_owner] && m_xfers < MB) m_d = word_of(m_owner);
            else begin
                m_busy = 0; m_last = m_owner;
            end
        end
    end

    // Per-cycle comparison plus independent burst and starvation monitors.
    logic [3:0] prev_req = '0, prev_gnt = '0;
    int         waitc [4];
    int         run = 0;

    initial forever begin
        logic [3:0] exp_gnt;
        int         gi, maxw;
        @(negedge clk);
        exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        chk("outputs", 16'({gnt_o, s1_o, s2_o, d_o, valid_o}),
            16'({exp_gnt, 2'(m_sel), m_d, m_busy}));
        chk("gnt_onehot", 16'($countones(gnt_o) <= 1), 16'd1);
        if (gnt_o != 0) begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (gnt_o[i]) gi = i;
            chk("sel_vs_gnt", 16'({s1_o, s2_o}), 16'(gi));
        end
        if (!rst_n) begin
            run = 0; prev_gnt = '0; prev_req = '0;
            for (int i = 0; i < 4; i++) waitc[i] = 0;
        end else begin
            if (gnt_o == 0) run = 0;
            else if (valid_o && ready) begin
                run++;
                chk("burst_len", 16'(run <= MB), 16'd1);
            end
            for (int i = 0; i < 4; i++) if (!prev_req[i]) waitc[i] = 0;
            if (gnt_o != 0 && prev_gnt == 0) begin
                maxw = 0;
                for (int i = 0; i < 4; i++) begin
                    if (gnt_o[i]) waitc[i] = 0;
                    else if (prev_req[i]) waitc[i]++;
                    if (waitc[i] > maxw) maxw = waitc[i];
                end
                chk("fairness", 16'(maxw <= 3), 16'd1);
            end
            prev_gnt = gnt_o;
            prev_req = req;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] req_tab [8] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] gnt_tab [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    logic [1:0] sel_tab [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [3:0] dat_tab [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
    logic [3:0] e_seq   [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

    initial begin
        logic [3:0] got;
        for (int i = 0; i < 4; i++) waitc[i] = 0;

        repeat (3) cyc();
        chk("reset_outputs", 16'({gnt_o, s1_o, s2_o, d_o, valid_o}), 16'd0);
        rst_n = 1'b1;

        // Full rotation F,E,C,B from reset with an idle cycle between grants.
        req = 4'b1111; ready = 1'b1; f = 4'h1; e = 4'h2; c = 4'h3; b = 4'h4;
        for (int s = 0; s < 8; s++) begin
            cyc();
            chk("rot_gnt", 16'(gnt_o), 16'(gnt_tab[s]));
            chk("rot_sel", 16'({s1_o, s2_o}), 16'(sel_tab[s]));
            chk("rot_d", 16'(d_o), 16'(dat_tab[s]));
            req = req_tab[s];
        end

        // Four-word burst from E, then forced release and re-grant.
        req = 4'b0010; e = e_seq[0];
        for (int s = 0; s < 4; s++) begin
            cyc();
            chk("burst_d", 16'({gnt_o, d_o, valid_o}), 16'({4'b0010, e_seq[s], 1'b1}));
            if (s < 3) e = e_seq[s + 1];
        end
        cyc();
        chk("burst_release", 16'({gnt_o, valid_o}), 16'd0);
        cyc();
        chk("burst_regrant", 16'(gnt_o), 16'h2);
        req = 4'b0000;
        cyc();
        cyc();

        // Stall holds D even as the owner's data and request change.
        req = 4'b0100; c = 4'h5; ready = 1'b0;
        cyc();
        chk("stall_grant", 16'({gnt_o, s1_o, s2_o, d_o, valid_o}), 16'({4'b0100, 2'b10, 4'h5, 1'b1}));
        c = 4'hF; req = 4'b0000;
        for (int s = 0; s < 3; s++) begin
            cyc();
            chk("stall_hold", 16'({d_o, valid_o}), 16'({4'h5, 1'b1}));
        end
        ready = 1'b1;
        cyc();
        chk("stall_accept", 16'({gnt_o, d_o, valid_o}), 16'({4'b0000, 4'h5, 1'b0}));

        // After B owns, F wins next, then B again while both keep requesting.
        req = 4'b1000;
        cyc();
        req = 4'b0000;
        cyc();
        chk("b_released", 16'(gnt_o), 16'd0);
        req = 4'b1001;
        cyc();
        chk("rr_f_after_b", 16'(gnt_o), 16'h1);
        got = '0;
        for (int k = 0; k < 12 && got == 0; k++) begin
            cyc();
            if (gnt_o != 0 && gnt_o != 4'b0001) got = gnt_o;
        end
        chk("rr_b_after_f", 16'(got), 16'h8);
        req = 4'b0000;
        cyc();
        cyc();

        // Asynchronous reset in the middle of E's grant.
        req = 4'b0010; e = 4'h7; ready = 1'b0;
        cyc();
        chk("pre_reset_gnt", 16'(gnt_o), 16'h2);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 16'({gnt_o, s1_o, s2_o, d_o, valid_o}), 16'd0);
        req = 4'b0100; c = 4'h9;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_c", 16'({gnt_o, d_o, valid_o}), 16'({4'b0100, 4'h9, 1'b1}));
        req = 4'b0000; ready = 1'b1;
        cyc();
        cyc();

        // Random traffic with sticky requests so that held requests occur.
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(3) == 0) req[i] = ~req[i];
            ready = ($urandom_range(9) < 7);
            f = 4'($urandom); e = 4'($urandom); c = 4'($urandom); b = 4'($urandom);
            cyc();
        end
        req = 4'b0000; ready = 1'b1;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/round_robin_mux_arbiter.md
ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, maximum transfers per grant before the grant is released (legal range 1-15).
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  4  request vector; bit0=F, bit1=E, bit2=C, bit3=B.
REQ-005 F, E, C, B  input  4 each  requester data words.
REQ-006 READY  input  1  downstream accepts D this cycle when VALID=1.
REQ-007 GNT  output  4  one-hot grant, same bit order as REQ.
REQ-008 S1, S2  output  1 each  select code of current owner: {S1,S2}=00 F, 01 E, 10 C, 11 B.
REQ-009 D  output  4  registered data of current owner.
REQ-010 VALID  output  1  D holds a word not yet accepted.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 FSM SHALL have two states: IDLE and GRANT.
REQ-013 IDLE, REQ=0: SHALL stay IDLE; GNT=0, VALID=0, D and {S1,S2} hold their last values.
REQ-014 IDLE, REQ!=0: winner SHALL be the first set REQ bit searching upward (wrapping 3->0) starting at LAST+1, where LAST is the index of the previous owner.
REQ-015 On that edge: state<=GRANT, GNT<=onehot(winner), {S1,S2}<=winner code, D<=winner's data input, VALID<=1, burst count<=0; latency REQ sampled -> VALID high = 1 cycle.
REQ-016 GRANT, VALID=1, READY=0 (stall): D, GNT, {S1,S2}, VALID, count SHALL hold; owner dropping REQ during stall SHALL NOT withdraw VALID.
REQ-017 GRANT, VALID&READY (transfer), REQ[owner]=1 and count+1<MAX_BURST: count<=count+1, D<=owner's current data input, VALID stays 1; back-to-back transfers one per cycle.
REQ-018 GRANT, transfer with REQ[owner]=0 or count+1=MAX_BURST: state<=IDLE, GNT<=0, VALID<=0, LAST<=owner, count<=0.
REQ-019 Release SHALL always pass through one IDLE cycle; the next grant appears no earlier than 2 cycles after the final transfer.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; no request is lost while held.
REQ-021 GNT SHALL never have more than one bit set; {S1,S2} SHALL always equal the code of the set GNT bit while GRANT.
REQ-022 MAX_BURST=1: every transfer SHALL release the grant.
REQ-023 Input data SHALL be sampled only on grant and on transfer edges; changes at other times SHALL NOT alter D.

Reset
REQ-024 RST_N=0 SHALL immediately, independent of CLK, force: state IDLE, GNT=0000, {S1,S2}=00, D=0000, VALID=0, count=0, LAST=3 (first priority F).
REQ-025 Reset asserted mid-burst SHALL abort the transfer with no further VALID; operation resumes on the first rising edge after RST_N=1.
REQ-026 REQ, READY and data inputs SHALL be ignored while RST_N=0.

Verification
REQ-027 Reset release, REQ=1111, READY=1, each REQ dropped after its first accept -> grants in order F,E,C,B (GNT 0001,0010,0100,1000; {S1,S2} 00,01,10,11), each separated by one IDLE cycle.
REQ-028 REQ=0010 held, E=4'hA then 4'hB, 4'hC, 4'hD per cycle, READY=1, MAX_BURST=4 -> D=A,B,C,D on four consecutive cycles, then GNT=0000, VALID=0 for one cycle, then E re-granted.
REQ-029 Owner C granted with D=4'h5, READY=0 for 3 cycles while C=4'hF and REQ[2] drops -> D=5, VALID=1 held 3 cycles; READY=1 -> accepted, grant released, D unchanged.
REQ-030 LAST=B (index 3), REQ=1001 -> F granted next; after F releases with REQ=1001 still -> B granted (fair rotation, no starvation).
REQ-031 RST_N pulsed low between clock edges during a burst from E -> GNT=0000, VALID=0, D=0000 without a clock edge; after release with REQ=0100 -> C granted one cycle later.
REQ-032 Random REQ/READY for 10,000 cycles -> GNT one-hot or zero always, {S1,S2} consistent with GNT, no owner exceeds MAX_BURST consecutive transfers, every held request served within 4 grants.
